// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss controller: hit/bypass to fetch, line-load issue,
// and an MSHR table that matches returning memory tags to cache fills.
module icache_fill_ctrl #(
  parameter int MSHR_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] proc2Icache_addr,
  input  logic [63:0] cache_data,
  input  logic        cache_valid,
  output logic [6:0]  rd_idx,
  output logic [53:0] rd_tag,
  output logic [63:0] Icache2proc_data,
  output logic        Icache2proc_valid,
  input  logic        bus_busy,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  input  logic [63:0] mem2proc_data,
  output logic        wr_en,
  output logic [6:0]  wr_idx,
  output logic [53:0] wr_tag,
  output logic [63:0] wr_data,
  output logic        mshr_full
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  mem_tag;
    logic [6:0]  idx;
    logic [53:0] tag;
  } mshr_t;

  mshr_t [MSHR_DEPTH-1:0] mshr;
  logic  [MSHR_DEPTH-1:0] valid, fill_hit, same_line, fill_oh, alloc_oh;
  logic                   bypass, issue, alloc;
  logic                   unused;

  assign rd_idx        = proc2Icache_addr[9:3];
  assign rd_tag        = proc2Icache_addr[63:10];
  assign proc2mem_addr = {proc2Icache_addr[63:3], 3'b0};
  assign unused        = ^proc2Icache_addr[2:0];

  for (genvar i = 0; i < MSHR_DEPTH; i++) begin : g_ent
    assign valid[i]     = mshr[i].valid;
    assign fill_hit[i]  = mshr[i].valid && (mem2proc_tag != 4'd0) && (mshr[i].mem_tag == mem2proc_tag);
    assign same_line[i] = mshr[i].valid && (mshr[i].idx == rd_idx) && (mshr[i].tag == rd_tag);
  end

  // Lowest-set one-hot picks: the matching fill entry and the free slot to allocate.
  assign fill_oh  = fill_hit & (~fill_hit + MSHR_DEPTH'(1));
  assign alloc_oh = ~valid & (valid + MSHR_DEPTH'(1));

  always_comb begin
    wr_idx = '0;
    wr_tag = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (fill_oh[i]) begin
        wr_idx = wr_idx | mshr[i].idx;
        wr_tag = wr_tag | mshr[i].tag;
      end
    end
  end

  assign wr_en   = !reset && (|fill_hit);
  assign wr_data = mem2proc_data;
  assign bypass  = wr_en && (wr_idx == rd_idx) && (wr_tag == rd_tag);

  assign Icache2proc_valid = !reset && (cache_valid || bypass);
  assign Icache2proc_data  = cache_valid ? cache_data : mem2proc_data;

  // Full is judged on entry state at cycle start; a same-cycle fill frees its slot next cycle.
  assign mshr_full        = !reset && (&valid);
  assign issue            = !reset && !Icache2proc_valid && !(|same_line) && !(&valid) && !bus_busy;
  assign proc2mem_command = issue ? 2'd1 : 2'd0;
  assign alloc            = issue && (mem2proc_response != 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_DEPTH; i++) mshr[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        if (fill_oh[i]) mshr[i].valid <= 1'b0;
        if (alloc && alloc_oh[i]) mshr[i] <= '{1'b1, mem2proc_response, rd_idx, rd_tag};
      end
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed plus randomized bench for icache_fill_ctrl against a queue model of outstanding loads.
module tb_icache_fill_ctrl;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset, cache_valid, bus_busy;
  logic [63:0] addr, cache_data, mem_data;
  logic [3:0]  resp, mtag;
  logic [6:0]  rd_idx, wr_idx;
  logic [53:0] rd_tag, wr_tag;
  logic [63:0] Icache2proc_data, proc2mem_addr, wr_data;
  logic        Icache2proc_valid, wr_en, mshr_full;
  logic [1:0]  proc2mem_command;

  icache_fill_ctrl #(.MSHR_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .proc2Icache_addr(addr), .cache_data(cache_data),
    .cache_valid(cache_valid), .rd_idx(rd_idx), .rd_tag(rd_tag),
    .Icache2proc_data(Icache2proc_data), .Icache2proc_valid(Icache2proc_valid),
    .bus_busy(bus_busy), .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .mem2proc_response(resp), .mem2proc_tag(mtag), .mem2proc_data(mem_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_data(wr_data), .mshr_full(mshr_full)
  );

  always #5 clock = ~clock;

  // Outstanding loads as the memory system sees them: tag handed back plus the line it fills.
  typedef struct {
    logic [3:0]  mt;
    logic [6:0]  idx;
    logic [53:0] tag;
  } ld_t;
  ld_t q[$];

  int errors = 0, checks = 0;
  bit e_fill, e_iss;
  int e_fi;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit tag_used(input logic [3:0] t);
    foreach (q[i]) if (q[i].mt == t) return 1'b1;
    return 1'b0;
  endfunction

  // Settle inputs, predict every output from the outstanding-load list, compare.
  task automatic eval();
    logic [6:0]  ri;
    logic [53:0] rt;
    bit byp, hit, dup, full;
    #1;
    ri = addr[9:3];
    rt = addr[63:10];
    e_fill = 1'b0;
    e_fi = -1;
    if (!reset && mtag != 4'd0)
      foreach (q[i]) if (!e_fill && q[i].mt == mtag) begin e_fill = 1'b1; e_fi = i; end
    byp = e_fill && q[e_fi].idx == ri && q[e_fi].tag == rt;
    hit = !reset && (cache_valid || byp);
    dup = 1'b0;
    foreach (q[i]) if (q[i].idx == ri && q[i].tag == rt) dup = 1'b1;
    full = !reset && (q.size() == D);
    e_iss = !reset && !hit && !dup && !full && !bus_busy;
    chk("rd_idx", rd_idx, ri);
    chk("rd_tag", rd_tag, rt);
    chk("command", proc2mem_command, e_iss ? 1 : 0);
    if (e_iss) chk("mem_addr", proc2mem_addr, {addr[63:3], 3'b0});
    chk("wr_en", wr_en, e_fill);
    if (e_fill) begin
      chk("wr_idx", wr_idx, q[e_fi].idx);
      chk("wr_tag", wr_tag, q[e_fi].tag);
      chk("wr_data", wr_data, mem_data);
    end
    chk("ic_valid", Icache2proc_valid, hit);
    if (hit) chk("ic_data", Icache2proc_data, cache_valid ? cache_data : mem_data);
    chk("mshr_full", mshr_full, full);
  endtask

  task automatic tick();
    ld_t n;
    @(posedge clock);
    if (reset) q.delete();
    else begin
      if (e_fill) q.delete(e_fi);
      if (e_iss && resp != 4'd0) begin
        n.mt = resp; n.idx = addr[9:3]; n.tag = addr[63:10];
        q.push_back(n);
      end
    end
    #1;
  endtask

  function automatic logic [63:0] mk(input int t, input int i);
    mk = (64'(t) << 10) | (64'(i) << 3);
  endfunction

  int loads;
  logic [63:0] pool[6];

  initial begin
    reset = 1'b1; cache_valid = 1'b1; bus_busy = 1'b0;
    addr = 64'h1008; cache_data = 64'h1111; mem_data = 64'h2222;
    resp = 4'd5; mtag = 4'd3;
    #2;
    // Reset hold
    repeat (2) begin
      eval();
      chk("rst_valid", Icache2proc_valid, 0);
      chk("rst_cmd", proc2mem_command, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_full", mshr_full, 0);
      tick();
    end
    reset = 1'b0;

    // Miss then no duplicate issue over 10 cycles
    cache_valid = 1'b0; mtag = 4'd0; resp = 4'd5; loads = 0;
    for (int c = 0; c < 10; c++) begin
      eval();
      if (proc2mem_command == 2'd1) loads++;
      if (c == 0) begin
        chk("miss_cmd", proc2mem_command, 1);
        chk("miss_addr", proc2mem_addr, 64'h1008);
      end
      tick();
    end
    chk("one_load", loads, 1);

    // Fill with bypass, then the entry is gone
    mtag = 4'd5; mem_data = 64'hDEADBEEF; resp = 4'd0;
    eval();
    chk("fill_wr_en", wr_en, 1);
    chk("fill_idx", wr_idx, 1);
    chk("fill_tag", wr_tag, 4);
    chk("byp_valid", Icache2proc_valid, 1);
    chk("byp_data", Icache2proc_data, 64'hDEADBEEF);
    tick();
    eval();
    chk("freed", wr_en, 0);
    tick();

    // Four misses, full, out-of-order returns, fifth miss waits
    mtag = 4'd0;
    for (int k = 0; k < 4; k++) begin
      addr = mk(k + 1, k + 2); resp = 4'(k + 1);
      eval();
      chk("ooo_issue", proc2mem_command, 1);
      tick();
    end
    addr = mk(9, 10); resp = 4'd6;
    eval();
    chk("full", mshr_full, 1);
    chk("full_noissue", proc2mem_command, 0);
    tick();
    mtag = 4'd3; mem_data = 64'h33;
    eval();
    chk("full_same_cyc", proc2mem_command, 0);
    chk("ret3_idx", wr_idx, 4);
    chk("ret3_tag", wr_tag, 3);
    tick();
    mtag = 4'd1; mem_data = 64'h11;
    eval();
    chk("fifth_issue", proc2mem_command, 1);
    chk("ret1_idx", wr_idx, 2);
    tick();
    resp = 4'd0;
    mtag = 4'd4; eval(); chk("ret4_idx", wr_idx, 5); tick();
    mtag = 4'd2; eval(); chk("ret2_tag", wr_tag, 2); tick();
    mtag = 4'd6; eval(); chk("ret6_byp", Icache2proc_valid, 1); tick();

    // Bus and response gating
    mtag = 4'd0; addr = mk(20, 30); bus_busy = 1'b1; resp = 4'd7;
    eval(); chk("busy_noissue", proc2mem_command, 0); tick();
    bus_busy = 1'b0; resp = 4'd0;
    eval(); chk("rej_issue", proc2mem_command, 1); tick();
    eval(); chk("rej_retry", proc2mem_command, 1); tick();
    resp = 4'd7;
    eval(); tick();
    resp = 4'd0; mtag = 4'd9;
    eval(); chk("foreign_tag", wr_en, 0); tick();
    mtag = 4'd7; eval(); tick();

    // Reset mid-operation
    mtag = 4'd0;
    addr = mk(40, 41); resp = 4'd1; eval(); tick();
    addr = mk(42, 43); resp = 4'd2; eval(); tick();
    reset = 1'b1; resp = 4'd0; eval(); tick();
    reset = 1'b0; bus_busy = 1'b1;
    mtag = 4'd1; eval(); chk("post_rst1", wr_en, 0); tick();
    mtag = 4'd2; eval(); chk("post_rst2", wr_en, 0); tick();
    bus_busy = 1'b0; mtag = 4'd0; addr = mk(50, 51); resp = 4'd3;
    eval(); chk("post_rst_issue", proc2mem_command, 1); tick();
    resp = 4'd0; mtag = 4'd3; addr = mk(60, 61);
    eval(); chk("post_rst_fill", wr_idx, 51); tick();

    // Randomized traffic over a small address pool
    foreach (pool[i]) pool[i] = {$urandom, $urandom};
    mtag = 4'd0;
    for (int c = 0; c < 400; c++) begin
      addr = pool[$urandom_range(5, 0)];
      cache_valid = ($urandom_range(3, 0) == 0);
      bus_busy = ($urandom_range(4, 0) == 0);
      reset = ($urandom_range(49, 0) == 0);
      cache_data = {$urandom, $urandom};
      mem_data = {$urandom, $urandom};
      resp = 4'd0;
      if ($urandom_range(3, 0) != 0)
        do resp = 4'($urandom_range(15, 1)); while (tag_used(resp));
      mtag = 4'd0;
      case ($urandom_range(4, 0))
        0, 1: if (q.size() > 0) mtag = q[$urandom_range(q.size() - 1, 0)].mt;
        2: do mtag = 4'($urandom_range(15, 1)); while (tag_used(mtag));
        default: mtag = 4'd0;
      endcase
      eval();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Instruction-cache miss controller between the fetch stage, the 128-line direct-mapped instruction cache, and the shared memory bus. It splits the fetch address into cache index and tag and reports hits to fetch. On a miss it issues a line load to memory and tracks up to `MSHR_DEPTH` outstanding loads by memory tag. When the matching response returns, it drives the cache write port and bypasses the returning data to fetch in the same cycle.

## Interface
- `MSHR_DEPTH`, 4: number of outstanding line loads (1..15).
- `clock` in 1: system clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `proc2Icache_addr` in 64: fetch address; bits [2:0] ignored.
- `cache_data` in 64: cache read data for `rd_idx`.
- `cache_valid` in 1: cache hit for `rd_idx`/`rd_tag`.
- `rd_idx` out 7: cache read index, `proc2Icache_addr[9:3]`.
- `rd_tag` out 54: cache read tag, `proc2Icache_addr[63:10]`.
- `Icache2proc_data` out 64: instruction data to fetch.
- `Icache2proc_valid` out 1: `Icache2proc_data` is valid this cycle.
- `bus_busy` in 1: data side owns the memory bus this cycle.
- `proc2mem_command` out 2: 0 = NONE, 1 = LOAD.
- `proc2mem_addr` out 64: `{proc2Icache_addr[63:3], 3'b0}`.
- `mem2proc_response` in 4: same-cycle accept tag; 0 = rejected.
- `mem2proc_tag` in 4: tag of returning data; 0 = no data.
- `mem2proc_data` in 64: returning line data.
- `wr_en` out 1: cache fill write enable.
- `wr_idx` out 7: cache fill index.
- `wr_tag` out 54: cache fill tag.
- `wr_data` out 64: cache fill data.
- `mshr_full` out 1: all MSHR entries are valid.

## Operation
- **MSHR entry contents:** `valid`, `mem_tag[3:0]`, `idx[6:0]`, `tag[53:0]`.
- **Fill match:**
  - Applies when `mem2proc_tag` != 0 and equals `mem_tag` of a valid entry.
  - Drives `wr_en`=1 combinationally, with `wr_idx`/`wr_tag` taken from that entry and `wr_data` = `mem2proc_data`.
  - The entry clears at the posedge.
  - A non-matching nonzero `mem2proc_tag` belongs to the data side and is ignored; `wr_en`=0.
- **Hit:**
  - When `cache_valid`=1, `Icache2proc_data` = `cache_data` and `Icache2proc_valid` = 1.
  - Otherwise, when a fill matches with `wr_idx`==`rd_idx` and `wr_tag`==`rd_tag`: bypass. `Icache2proc_data` = `mem2proc_data` and `Icache2proc_valid` = 1.
  - Otherwise `Icache2proc_valid` = 0.
- **Issue:** `proc2mem_command`=LOAD only when all of the following hold:
  - not a hit and not a bypass;
  - no valid entry has the same `idx` and `tag`;
  - `mshr_full`=0;
  - `bus_busy`=0;
  - `reset`=0.
- **Allocate:**
  - At the posedge of an issue cycle, if `mem2proc_response` != 0, the lowest-numbered invalid entry is written with `{1, response, rd_idx, rd_tag}`.
  - If `mem2proc_response`=0, nothing is allocated; the request is re-evaluated next cycle.
- **Simultaneous fill and allocate:** allowed in one cycle. The allocation only selects entries invalid at cycle start, so it never targets the entry being freed.
- **Redirect:** an address change while loads are outstanding does not cancel them. Every outstanding entry still fills the cache when its response arrives.
- **`mshr_full`:** derived from current entry valids only. A fill in the same cycle does not free a slot for issue until the next cycle.
- **Reset:**
  - All entries go invalid.
  - While `reset`=1: `proc2mem_command`=NONE, `wr_en`=0, `Icache2proc_valid`=0, `mshr_full`=0.
  - Any fill arriving during reset is dropped.

## Timing
- Hit: 0-cycle latency, combinational from address to `Icache2proc_valid`.
- Miss:
  - Cycle 0: LOAD issued and accepted; entry allocated at the end of cycle 0.
  - Cycle N: response tag arrives; bypass data and `wr_en` are valid in cycle N; the cache line is written at the end of N.
  - Cycle N+1: hit from the cache.
- Issue and fill paths are combinational from the inputs; only MSHR state is registered.
- Up to `MSHR_DEPTH` loads may be outstanding, completing in any order.

## Test plan
- **Reset hold:** hold `reset`=1 with an address, `cache_valid`=1 and `mem2proc_tag`=3 -> `Icache2proc_valid`=0, command NONE, `wr_en`=0. After release, all entries are invalid.
- **Miss then fill:** miss at address 0x1008 (`idx`=1), `response`=5. Later `mem2proc_tag`=5 with data 0xDEADBEEF -> `wr_en`=1, `wr_idx`=1, `wr_tag`=4, bypass valid with 0xDEADBEEF in the same cycle; the entry is freed next cycle.
- **No duplicate issue:** hold the same missing address for 10 cycles with no response -> exactly one LOAD, with no further issue in cycles 1..9.
- **Out-of-order completion, full, and refusal:**
  - Four distinct misses with tags 1,2,3,4 -> `mshr_full`=1 and a fifth miss issues nothing.
  - Return tags in the order 3,1,4,2 -> each fill writes its own `idx`/`tag`.
  - A fifth miss while full -> no LOAD; the fifth LOAD is issued the cycle after the first fill.
- **Bus and response gating:**
  - `bus_busy`=1 -> no LOAD.
  - `mem2proc_response`=0 -> no allocation, LOAD retried next cycle.
  - `mem2proc_tag`=9 with no matching entry -> `wr_en`=0.
- **Reset mid-operation:** reset with two loads outstanding, then return their tags -> `wr_en`=0 for both, and a new miss allocates entry 0.
